// File: rtl/uart_pkg.sv
// Shared UART types and frame constants for the transmitter (uart_top) and receiver (uart_rx).
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, half-bit start recheck, mid-bit sampling, framing error flag.
//  state    | meaning
//  RX_IDLE  | waiting for synchronized high-to-low edge
//  RX_START | half-bit wait, then confirm start bit still low
//  RX_DATA  | sampling 8 data bits, LSB first, one per bit time
//  RX_STOP  | sampling stop bit; high = good frame, low = framing error
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_error
);

    localparam logic [CNT_W-1:0]     BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]     HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);

    logic                 r_sync1, r_sync2, r_sync3;
    rx_state_t            r_state, w_state_nx;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nx;
    logic [BIT_IDX_W-1:0] r_bit, w_bit_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic [DATA_BITS-1:0] r_data, w_data_nx;
    logic                 r_valid, w_valid_nx;
    logic                 r_error, w_error_nx;
    logic                 w_cnt_zero;

    // r_sync3 only serves the falling-edge detect on the synchronized line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_data  <= w_data_nx;
            r_valid <= w_valid_nx;
            r_error <= w_error_nx;
        end
    end

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_data_nx  = r_data;
        w_valid_nx = 1'b0;
        w_error_nx = r_error;
        case (r_state)
            RX_IDLE: begin
                if (r_sync3 && !r_sync2) begin
                    w_state_nx = RX_START;
                    w_cnt_nx   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (!w_cnt_zero) begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end else if (r_sync2) begin
                    w_state_nx = RX_IDLE;
                end else begin
                    w_state_nx = RX_DATA;
                    w_cnt_nx   = BIT_LOAD;
                    w_bit_nx   = '0;
                end
            end
            RX_DATA: begin
                if (!w_cnt_zero) begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end else begin
                    w_shift_nx = {r_sync2, r_shift[DATA_BITS-1:1]};
                    w_cnt_nx   = BIT_LOAD;
                    if (r_bit == LAST_BIT) begin
                        w_state_nx = RX_STOP;
                    end else begin
                        w_bit_nx = r_bit + BIT_IDX_W'(1);
                    end
                end
            end
            RX_STOP: begin
                if (!w_cnt_zero) begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end else begin
                    // back to idle at the stop sample so a new start edge is caught right away
                    w_state_nx = RX_IDLE;
                    if (r_sync2) begin
                        w_data_nx  = r_shift;
                        w_valid_nx = 1'b1;
                        w_error_nx = 1'b0;
                    end else begin
                        w_error_nx = 1'b1;
                    end
                end
            end
            default: w_state_nx = RX_IDLE;
        endcase
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_error = r_error;

endmodule

// File: rtl/uart_top.sv
// 8N1 UART: edge-triggered transmitter plus uart_rx receiver, running independently.
// Define UART_LOOPBACK_EN to feed the receiver from the internal TxD instead of the RxD pin.
//  state    | meaning
//  TX_IDLE  | line high, waiting for a new_in rising edge
//  TX_START | driving start bit (0)
//  TX_DATA  | driving 8 data bits, LSB first
//  TX_STOP  | driving stop bit (1); tx_busy drops after its last cycle
module uart_top
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] datain_ext,
    input  logic                 new_in,
    output logic                 TxD,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] dataout_ext,
    output logic                 new_out,
    output logic                 error,
    output logic                 tx_busy
);

    localparam logic [CNT_W-1:0]     BIT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    logic                 r_new_in;
    tx_state_t            r_tx_state, w_tx_state_nx;
    logic [CNT_W-1:0]     r_tx_cnt, w_tx_cnt_nx;
    logic [BIT_IDX_W-1:0] r_tx_bit, w_tx_bit_nx;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nx;
    logic                 r_txd, w_txd_nx;
    logic                 r_tx_busy, w_tx_busy_nx;
    logic                 w_new_in_rise;
    logic                 w_tx_cnt_zero;
    logic                 w_rx_in;

    assign w_new_in_rise = new_in && !r_new_in;
    assign w_tx_cnt_zero = (r_tx_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_new_in   <= 1'b0;
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_new_in   <= new_in;
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_txd      <= w_txd_nx;
            r_tx_busy  <= w_tx_busy_nx;
        end
    end

    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_shift_nx = r_tx_shift;
        w_txd_nx      = r_txd;
        w_tx_busy_nx  = r_tx_busy;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_new_in_rise) begin
                    w_tx_state_nx = TX_START;
                    w_tx_cnt_nx   = BIT_LOAD;
                    w_tx_shift_nx = datain_ext;
                    w_txd_nx      = 1'b0;
                    w_tx_busy_nx  = 1'b1;
                end
            end
            TX_START: begin
                if (!w_tx_cnt_zero) begin
                    w_tx_cnt_nx = r_tx_cnt - CNT_W'(1);
                end else begin
                    w_tx_state_nx = TX_DATA;
                    w_tx_cnt_nx   = BIT_LOAD;
                    w_tx_bit_nx   = '0;
                    w_txd_nx      = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (!w_tx_cnt_zero) begin
                    w_tx_cnt_nx = r_tx_cnt - CNT_W'(1);
                end else begin
                    w_tx_cnt_nx = BIT_LOAD;
                    if (r_tx_bit == LAST_BIT) begin
                        w_tx_state_nx = TX_STOP;
                        w_txd_nx      = 1'b1;
                    end else begin
                        w_tx_bit_nx   = r_tx_bit + BIT_IDX_W'(1);
                        w_tx_shift_nx = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                        w_txd_nx      = r_tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (!w_tx_cnt_zero) begin
                    w_tx_cnt_nx = r_tx_cnt - CNT_W'(1);
                end else begin
                    w_tx_state_nx = TX_IDLE;
                    w_tx_busy_nx  = 1'b0;
                end
            end
            default: begin
                w_tx_state_nx = TX_IDLE;
                w_txd_nx      = 1'b1;
                w_tx_busy_nx  = 1'b0;
            end
        endcase
    end

`ifdef UART_LOOPBACK_EN
    assign w_rx_in = r_txd;
`else
    assign w_rx_in = RxD;
`endif

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk     (clk),
        .rst_n   (rst),
        .i_rx    (w_rx_in),
        .o_data  (dataout_ext),
        .o_valid (new_out),
        .o_error (error)
    );

    assign TxD     = r_txd;
    assign tx_busy = r_tx_busy;

endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top: frame-level reference model with randomized bytes.
module tb_uart_top;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] datain_ext;
    logic       new_in;
    logic       TxD;
    logic       RxD;
    logic [7:0] dataout_ext;
    logic       new_out;
    logic       error;
    logic       tx_busy;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc;
    int         pulses;
    int         pulse_cyc;
    logic [7:0] pulse_data;
    logic [7:0] exp_data = 8'h00;
    logic       exp_err  = 1'b0;

    uart_top #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .datain_ext  (datain_ext),
        .new_in      (new_in),
        .TxD         (TxD),
        .RxD         (RxD),
        .dataout_ext (dataout_ext),
        .new_out     (new_out),
        .error       (error),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Bit k of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic send_tx(input logic [7:0] b, input int hold, input int edge2_at);
        int bad    = 0;
        int busy_n = 0;
        int extra  = 0;
        @(negedge clk);
        datain_ext = b;
        new_in     = 1'b1;
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            if (TxD !== frame_bit(b, i / CPB)) bad++;
            if (tx_busy === 1'b1) busy_n++;
            if (i % CPB == CPB / 2)
                check($sformatf("tx_bit%0d_%02h", i / CPB, b), 32'(TxD), 32'(frame_bit(b, i / CPB)));
            if (i == hold) new_in = 1'b0;
            if (edge2_at > 0 && i == edge2_at) new_in = 1'b1;
            if (edge2_at > 0 && i == edge2_at + 3) new_in = 1'b0;
        end
        new_in = 1'b0;
        check("tx_bit_stable", bad, 0);
        check("tx_busy_len", busy_n, 10 * CPB);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || tx_busy !== 1'b0) extra++;
        end
        check("tx_no_extra_frame", extra, 0);
    endtask

    task automatic tick();
        @(negedge clk);
        if (new_out === 1'b1) begin
            pulses++;
            pulse_cyc  = cyc;
            pulse_data = dataout_ext;
        end
        cyc++;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        pulses    = 0;
        pulse_cyc = -1;
        cyc       = 0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < CPB; j++) begin
                tick();
                RxD = (k == 9) ? stop : frame_bit(b, k);
            end
        end
        for (int j = 0; j < 30; j++) begin
            tick();
            RxD = 1'b1;
        end
        if (stop) begin
            exp_data = b;
            exp_err  = 1'b0;
            check("rx_pulse_count", pulses, 1);
            check("rx_pulse_data", 32'(pulse_data), 32'(b));
            // mid-stop sample is 9.5 bit times after the start edge, plus synchronizer latency
            check("rx_pulse_time", 32'(pulse_cyc >= 9 * CPB + CPB / 2 - 4 && pulse_cyc <= 10 * CPB), 1);
        end else begin
            exp_err = 1'b1;
            check("rx_ferr_no_pulse", pulses, 0);
        end
        check("rx_error", 32'(error), 32'(exp_err));
        check("rx_dataout", 32'(dataout_ext), 32'(exp_data));
    endtask

    initial begin
        logic [7:0] rb;
        rst_n      = 1'b0;
        RxD        = 1'b1;
        new_in     = 1'b0;
        datain_ext = 8'h00;
        repeat (50) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_txd", 32'(TxD), 1);
        check("rst_error", 32'(error), 0);
        check("rst_new_out", 32'(new_out), 0);
        check("rst_dataout", 32'(dataout_ext), 0);
        check("rst_tx_busy", 32'(tx_busy), 0);

        send_tx(8'd31, 50, 0);
        send_tx(8'd65, 1, 70);
        for (int n = 0; n < 3; n++) begin
            rb = 8'($urandom_range(0, 255));
            send_tx(rb, $urandom_range(1, 100), ($urandom_range(0, 1) == 1) ? 60 : 0);
        end

`ifdef UART_LOOPBACK_EN
        RxD = 1'b0;
        send_tx(8'd31, 3, 0);
        check("loop_dataout", 32'(dataout_ext), 31);
        check("loop_error", 32'(error), 0);
        RxD = 1'b1;
`else
        rx_frame(8'h41, 1'b1);
        rx_frame(8'hA5, 1'b0);
        rx_frame(8'h5A, 1'b1);

        pulses = 0;
        cyc    = 0;
        tick();
        RxD = 1'b0;
        repeat (4) tick();
        RxD = 1'b1;
        repeat (40) tick();
        check("glitch_no_pulse", pulses, 0);
        check("glitch_error", 32'(error), 32'(exp_err));
        check("glitch_dataout", 32'(dataout_ext), 32'(exp_data));

        for (int n = 0; n < 4; n++) begin
            rb = 8'($urandom_range(0, 255));
            rx_frame(rb, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        rb = 8'($urandom_range(0, 255));
        fork
            send_tx(8'($urandom_range(0, 255)), 2, 0);
            rx_frame(rb, 1'b1);
        join
`endif

        @(negedge clk);
        datain_ext = 8'h00;
        new_in     = 1'b1;
        repeat (40) @(negedge clk);
        check("midframe_busy", 32'(tx_busy), 1);
        check("midframe_txd_low", 32'(TxD), 0);
        rst_n = 1'b0;
        #1;
        check("abort_txd", 32'(TxD), 1);
        check("abort_busy", 32'(tx_busy), 0);
        check("abort_dataout", 32'(dataout_ext), 0);
        new_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_abort_txd", 32'(TxD), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
